// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with filtered SCL/SDA inputs, 7-bit address match, write streaming and read fetch.
// SDA is open-drain; the FSM reacts to edges of the filtered lines.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         FILTER_LEN = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl,
   inout  wire        sda,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_load,
   output logic       rd_nack,
   output logic       addressed,
   output logic       rw
);
   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CMAX = CW'(FILTER_LEN - 1);

   typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
   logic          scl_f_q, scl_f_d, sda_f_q, sda_f_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d, rx_data_q, rx_data_d, byte_in;
   logic          ack_q, ack_d, oe_q, oe_d, addressed_q, addressed_d, rw_q, rw_d;
   logic          rx_valid_q, rx_valid_d, tx_load_q, tx_load_d, rd_nack_q, rd_nack_d;
   logic          scl_rise, scl_fall, start_c, stop_c;

   // filtered copy follows a synced level only after it has held for FILTER_LEN cycles
   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl};
      sda_sync_d = {sda_sync_q[0], sda};
      scl_cnt_d  = (scl_sync_q[1] != scl_f_q && scl_cnt_q != CMAX) ? scl_cnt_q + 1'b1 : '0;
      sda_cnt_d  = (sda_sync_q[1] != sda_f_q && sda_cnt_q != CMAX) ? sda_cnt_q + 1'b1 : '0;
      scl_f_d    = (scl_sync_q[1] != scl_f_q && scl_cnt_q == CMAX) ? scl_sync_q[1] : scl_f_q;
      sda_f_d    = (sda_sync_q[1] != sda_f_q && sda_cnt_q == CMAX) ? sda_sync_q[1] : sda_f_q;
   end

   assign scl_rise = ~scl_f_q & scl_f_d;
   assign scl_fall = scl_f_q & ~scl_f_d;
   assign start_c  = scl_f_q & scl_f_d & sda_f_q & ~sda_f_d;
   assign stop_c   = scl_f_q & scl_f_d & ~sda_f_q & sda_f_d;
   assign byte_in  = {shreg_q[6:0], sda_f_q};

   // bit_cnt doubles as the two-fall phase counter inside the ACK states
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      ack_d       = ack_q;
      oe_d        = oe_q;
      addressed_d = addressed_q;
      rw_d        = rw_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      tx_load_d   = 1'b0;
      rd_nack_d   = 1'b0;
      if (start_c) begin
         state_d     = ADDR;
         bit_cnt_d   = 3'd0;
         oe_d        = 1'b0;
         addressed_d = 1'b0;
      end else if (stop_c) begin
         state_d     = IDLE;
         oe_d        = 1'b0;
         addressed_d = 1'b0;
      end else if (tx_load_q) begin
         shreg_d = tx_data;
         oe_d    = ~tx_data[7];
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               shreg_d   = byte_in;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                  rw_d    = (byte_in[7:1] == SLAVE_ADDR) ? byte_in[0] : rw_q;
               end
            end
            WR_DATA: if (scl_rise) begin
               shreg_d   = byte_in;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d    = WR_ACK;
                  ack_d      = rx_ready;
                  rx_valid_d = rx_ready;
                  rx_data_d  = rx_ready ? byte_in : rx_data_q;
               end
            end
            ADDR_ACK: if (scl_fall) begin
               bit_cnt_d   = (bit_cnt_q == 3'd0) ? 3'd1 : 3'd0;
               oe_d        = (bit_cnt_q == 3'd0);
               addressed_d = 1'b1;
               if (bit_cnt_q != 3'd0) begin
                  state_d   = rw_q ? RD_DATA : WR_DATA;
                  tx_load_d = rw_q;
               end
            end
            WR_ACK: if (scl_fall) begin
               bit_cnt_d = (bit_cnt_q == 3'd0) ? 3'd1 : 3'd0;
               oe_d      = (bit_cnt_q == 3'd0) & ack_q;
               if (bit_cnt_q != 3'd0) begin
                  state_d     = ack_q ? WR_DATA : IGNORE;
                  addressed_d = ack_q;
               end
            end
            RD_DATA: if (scl_fall) begin
               if (bit_cnt_q == 3'd7) begin
                  state_d   = RD_ACK;
                  oe_d      = 1'b0;
                  bit_cnt_d = 3'd0;
                  ack_d     = 1'b0;
               end else begin
                  shreg_d   = {shreg_q[6:0], 1'b0};
                  oe_d      = ~shreg_q[6];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            RD_ACK: if (scl_rise) begin
               ack_d = ~sda_f_q;
               if (sda_f_q) begin
                  rd_nack_d   = 1'b1;
                  addressed_d = 1'b0;
                  state_d     = IGNORE;
               end
            end else if (scl_fall && ack_q) begin
               state_d   = RD_DATA;
               tx_load_d = 1'b1;
               ack_d     = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q  <= 2'b11;
         sda_sync_q  <= 2'b11;
         scl_cnt_q   <= '0;
         sda_cnt_q   <= '0;
         scl_f_q     <= 1'b1;
         sda_f_q     <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         shreg_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         ack_q       <= 1'b0;
         oe_q        <= 1'b0;
         addressed_q <= 1'b0;
         rw_q        <= 1'b0;
         rx_valid_q  <= 1'b0;
         tx_load_q   <= 1'b0;
         rd_nack_q   <= 1'b0;
      end else begin
         scl_sync_q  <= scl_sync_d;
         sda_sync_q  <= sda_sync_d;
         scl_cnt_q   <= scl_cnt_d;
         sda_cnt_q   <= sda_cnt_d;
         scl_f_q     <= scl_f_d;
         sda_f_q     <= sda_f_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         rx_data_q   <= rx_data_d;
         ack_q       <= ack_d;
         oe_q        <= oe_d;
         addressed_q <= addressed_d;
         rw_q        <= rw_d;
         rx_valid_q  <= rx_valid_d;
         tx_load_q   <= tx_load_d;
         rd_nack_q   <= rd_nack_d;
      end
   end

   assign sda       = oe_q ? 1'b0 : 1'bz;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign tx_load   = tx_load_q;
   assign rd_nack   = rd_nack_q;
   assign addressed = addressed_q;
   assign rw        = rw_q;
endmodule
